// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, idle line level and even parity.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_HOLD   = 3'd5
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Callers zero-extend their data word; zero bits do not change the parity.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a one-cycle tick
// in the last cycle of each period. Shared with the receive stage.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge sys_clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_fake_tx.sv
// Fake-interface UART transmitter fed by the MITM logic.
// Define UART_FAKE_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module uart_fake_tx
    import uart_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 104,
    parameter int NUM_STOP_BITS = 1
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     send_start,
    input  logic [NUM_DATA_BITS-1:0] send_data,
    input  logic                     keep_alive,
    output logic                     send_ready,
    output logic                     send_done,
    output logic                     tx_out,
    output logic                     tx_active
);
    localparam int BW = $clog2(NUM_DATA_BITS + 1);

    tx_state_t                state, state_nxt;
    logic [NUM_DATA_BITS-1:0] shift;
    logic [BW-1:0]            bit_cnt;
    logic                     done_q;
    logic                     rdy_en;
    logic                     tick;
    logic                     accept;
    logic                     data_last;
    logic                     stop_end;
`ifdef UART_FAKE_TX_PARITY_EN
    logic                     par_q;
`endif

    // rdy_en keeps send_ready low through reset and for the reset cycle itself.
    assign send_ready = rdy_en && (state == ST_IDLE || state == ST_HOLD);
    assign accept     = send_ready && send_start;
    assign data_last  = (bit_cnt == BW'(NUM_DATA_BITS - 1));
    assign stop_end   = (state == ST_STOP) && tick && (bit_cnt == BW'(NUM_STOP_BITS - 1));
    assign send_done  = done_q;

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (accept),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_START;
            ST_START: if (tick) state_nxt = ST_DATA;
            ST_DATA:
                if (tick && data_last) begin
`ifdef UART_FAKE_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
`ifdef UART_FAKE_TX_PARITY_EN
            ST_PARITY: if (tick) state_nxt = ST_STOP;
`endif
            ST_STOP:
                if (stop_end) state_nxt = keep_alive ? ST_HOLD : ST_IDLE;
            ST_HOLD:
                if (accept)
                    state_nxt = ST_START;
                else if (!keep_alive)
                    state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_out = LINE_IDLE;
        case (state)
            ST_START:  tx_out = 1'b0;
            ST_DATA:   tx_out = shift[0];
`ifdef UART_FAKE_TX_PARITY_EN
            ST_PARITY: tx_out = par_q;
`endif
            default:   tx_out = LINE_IDLE;
        endcase
        // done_q stretches tx_active over the done cycle when the FSM is already back in IDLE.
        tx_active = (state != ST_IDLE) || done_q;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rdy_en  <= 1'b0;
            done_q  <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            rdy_en <= 1'b1;
            done_q <= stop_end;
            if (accept) begin
                shift   <= send_data;
                bit_cnt <= '0;
            end else if (tick) begin
                if (state == ST_DATA) begin
                    shift   <= shift >> 1;
                    bit_cnt <= data_last ? '0 : bit_cnt + BW'(1);
                end else if (state == ST_STOP) begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

`ifdef UART_FAKE_TX_PARITY_EN
    always_ff @(posedge sys_clk) begin
        if (rst)
            par_q <= 1'b0;
        else if (accept)
            par_q <= even_parity(32'(send_data));
    end
`endif

endmodule

// File: tb/tb_uart_fake_tx.sv
// Directed/random bench for uart_fake_tx at CLKS_PER_BIT=4; honours UART_FAKE_TX_PARITY_EN.
module tb_uart_fake_tx;
    localparam int CPB = 4;
    localparam int NDB = 8;
    localparam int NSB = 1;
`ifdef UART_FAKE_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = CPB * (1 + NDB + P + NSB);

    logic       sys_clk = 1'b0;
    logic       rst, send_start, keep_alive;
    logic [7:0] send_data;
    logic       send_ready, send_done, tx_out, tx_active;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    uart_fake_tx #(.NUM_DATA_BITS(NDB), .CLKS_PER_BIT(CPB), .NUM_STOP_BITS(NSB)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .send_start (send_start),
        .send_data  (send_data),
        .keep_alive (keep_alive),
        .send_ready (send_ready),
        .send_done  (send_done),
        .tx_out     (tx_out),
        .tx_active  (tx_active)
    );

    // Line level for bit slot idx of a frame: start, data LSB first, optional parity, stops.
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= NDB) return d[idx-1];
        if (P == 1 && idx == NDB + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Entered mid-cycle with the DUT ready; that cycle is cycle 0 of the frame.
    task automatic frame(input logic [7:0] d, input int poke_at, input int abort_at);
        chk("ready_at_start", 0, send_ready, 1);
        send_start = 1'b1;
        send_data  = d;
        for (int c = 1; c <= F + 1; c++) begin
            tick();
            send_start = (c == poke_at);
            send_data  = 8'($urandom);
            if (abort_at != 0 && c == abort_at) rst = 1'b1;
            @(negedge sys_clk);
            if (abort_at != 0 && c == abort_at + 1) begin
                chk("abort_tx_out", c, tx_out, 1);
                chk("abort_done", c, send_done, 0);
                chk("abort_active", c, tx_active, 0);
                chk("abort_ready", c, send_ready, 0);
                rst = 1'b0;
                return;
            end
            chk("tx_out", c, tx_out, (c <= F) ? exp_bit(d, (c - 1) / CPB) : 1'b1);
            chk("send_done", c, send_done, (c == F + 1));
            chk("send_ready", c, send_ready, (c == F + 1));
            chk("tx_active", c, tx_active, 1);
        end
    endtask

    task automatic idle_chk(input string tag);
        tick();
        @(negedge sys_clk);
        chk({tag, "_active"}, 0, tx_active, 0);
        chk({tag, "_ready"}, 0, send_ready, 1);
        chk({tag, "_tx"}, 0, tx_out, 1);
        chk({tag, "_done"}, 0, send_done, 0);
    endtask

    initial begin
        rst        = 1'b1;
        send_start = 1'b0;
        keep_alive = 1'b0;
        send_data  = 8'h00;
        tick();
        tick();
        @(negedge sys_clk);
        chk("rst_ready", 0, send_ready, 0);
        chk("rst_tx", 0, tx_out, 1);
        chk("rst_active", 0, tx_active, 0);
        chk("rst_done", 0, send_done, 0);
        rst = 1'b0;
        idle_chk("post_rst");

        frame(8'h23, 0, 0);
        idle_chk("after_23");

        // Start pulse mid-frame must be ignored; the following idle check sees no second done.
        frame(8'($urandom), 10, 0);
        idle_chk("after_poke");
        idle_chk("after_poke2");

        // Back-to-back without keep_alive, started in the done cycle.
        for (int i = 0; i < 3; i++) frame(8'($urandom), 0, 0);
        idle_chk("after_rand");

        keep_alive = 1'b1;
        frame(8'h24, 0, 0);
        frame(8'h4E, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge sys_clk);
            chk("hold_active", i, tx_active, 1);
            chk("hold_ready", i, send_ready, 1);
            chk("hold_tx", i, tx_out, 1);
            chk("hold_done", i, send_done, 0);
        end
        frame(8'($urandom), 0, 0);
        keep_alive = 1'b0;
        idle_chk("hold_release");

        frame(8'($urandom), 0, 15);
        idle_chk("post_abort");
        for (int i = 0; i < 6; i++) idle_chk("abort_quiet");
        frame(8'($urandom), 0, 0);
        idle_chk("after_recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
